// File: rtl/ifm_buf_pkg.sv
// Shared opcodes, byte-lane offsets and row-operation encoding for the 3x3 IFM window buffer.
package ifm_pkg;

  localparam logic [2:0] IFM_ALL   = 3'b000;
  localparam logic [2:0] IFM_RIGHT = 3'b001;
  localparam logic [2:0] IFM_DOWN  = 3'b010;
  localparam logic [2:0] IFM_LEFT  = 3'b100;
  localparam logic [2:0] IFM_KEEP  = 3'b111;

  // Column 0 sits in the most significant pixel lane of the packed word.
  localparam int COL0_LSB = 16;
  localparam int COL1_LSB = 8;
  localparam int COL2_LSB = 0;

  typedef enum logic [1:0] {
    ROW_HOLD = 2'b00,
    ROW_LOAD = 2'b01,
    ROW_SHL  = 2'b10,
    ROW_SHR  = 2'b11
  } row_op_e;

  function automatic int col_lsb(input int col, input int pix_w);
    return (2 - col) * pix_w;
  endfunction

endpackage

// File: rtl/ifm_buf_if.sv
// Window-buffer bus: opcode, three packed row words in, nine window pixels out.
interface ifm_buf_if #(
  parameter int input_width  = 32,
  parameter int output_width = 8
);

  logic        [2:0]              ifm_read;
  logic        [input_width-1:0]  ifm_input0;
  logic        [input_width-1:0]  ifm_input1;
  logic        [input_width-1:0]  ifm_input2;
  logic signed [output_width-1:0] ifm_output0;
  logic signed [output_width-1:0] ifm_output1;
  logic signed [output_width-1:0] ifm_output2;
  logic signed [output_width-1:0] ifm_output3;
  logic signed [output_width-1:0] ifm_output4;
  logic signed [output_width-1:0] ifm_output5;
  logic signed [output_width-1:0] ifm_output6;
  logic signed [output_width-1:0] ifm_output7;
  logic signed [output_width-1:0] ifm_output8;

  modport master (
    output ifm_read, ifm_input0, ifm_input1, ifm_input2,
    input  ifm_output0, ifm_output1, ifm_output2, ifm_output3, ifm_output4,
           ifm_output5, ifm_output6, ifm_output7, ifm_output8
  );

  modport slave (
    input  ifm_read, ifm_input0, ifm_input1, ifm_input2,
    output ifm_output0, ifm_output1, ifm_output2, ifm_output3, ifm_output4,
           ifm_output5, ifm_output6, ifm_output7, ifm_output8
  );

endinterface

// File: rtl/ifm_buf_row.sv
// One 3-pixel window row: parallel load, shift toward column 0, shift toward column 2, hold.
// Registered outputs, one clock from op_i to row_o.
module ifm_buf_row
  import ifm_pkg::*;
#(
  parameter int pix_w = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  row_op_e            op_i,
  input  logic [3*pix_w-1:0] load_i,
  input  logic [pix_w-1:0]   in_right_i,
  input  logic [pix_w-1:0]   in_left_i,
  output logic [3*pix_w-1:0] row_o
);

  logic [pix_w-1:0] pix_q [3];
  logic [pix_w-1:0] pix_d [3];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pix_d[c] = pix_q[c];
    end
    unique case (op_i)
      ROW_LOAD: begin
        for (int c = 0; c < 3; c++) begin
          pix_d[c] = load_i[col_lsb(c, pix_w) +: pix_w];
        end
      end
      ROW_SHL: begin
        pix_d[0] = pix_q[1];
        pix_d[1] = pix_q[2];
        pix_d[2] = in_right_i;
      end
      ROW_SHR: begin
        pix_d[2] = pix_q[1];
        pix_d[1] = pix_q[0];
        pix_d[0] = in_left_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        pix_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        pix_q[c] <= pix_d[c];
      end
    end
  end

  assign row_o = {pix_q[0], pix_q[1], pix_q[2]};

endmodule

// File: rtl/ifm_buf.sv
// 3x3 IFM window register feeding the PE array; full load or one-pixel slide right/down/left.
// Outputs come straight from registers, one clock after the opcode is sampled.
module ifm_buf
  import ifm_pkg::*;
#(
  parameter int input_width  = 32,
  parameter int output_width = 8
) (
  input logic      clk,
  input logic      rst_n,
  ifm_buf_if.slave bus
);

  localparam int OW = output_width;
  localparam int RW = 3 * output_width;

  logic [RW-1:0] lane [3];
  logic [RW-1:0] row_q [3];
  logic [RW-1:0] load_src [3];
  row_op_e       row_op;
  logic          sel_down;
  logic          unused_hi;

  assign lane[0] = bus.ifm_input0[RW-1:0];
  assign lane[1] = bus.ifm_input1[RW-1:0];
  assign lane[2] = bus.ifm_input2[RW-1:0];

  assign unused_hi = ^{bus.ifm_input0[input_width-1:RW],
                       bus.ifm_input1[input_width-1:RW],
                       bus.ifm_input2[input_width-1:RW]};

  // Undefined and unknown opcodes fall through to hold.
  always_comb begin
    row_op   = ROW_HOLD;
    sel_down = 1'b0;
    case (bus.ifm_read)
      IFM_ALL:   row_op = ROW_LOAD;
      IFM_RIGHT: row_op = ROW_SHL;
      IFM_LEFT:  row_op = ROW_SHR;
      IFM_DOWN: begin
        row_op   = ROW_LOAD;
        sel_down = 1'b1;
      end
      default:   row_op = ROW_HOLD;
    endcase
  end

  // A down slide reloads each row from the one beneath; the bottom row takes ifm_input2.
  always_comb begin
    load_src[0] = sel_down ? row_q[1] : lane[0];
    load_src[1] = sel_down ? row_q[2] : lane[1];
    load_src[2] = lane[2];
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    ifm_buf_row #(
      .pix_w (OW)
    ) u_row (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_i       (row_op),
      .load_i     (load_src[r]),
      .in_right_i (lane[r][col_lsb(2, OW) +: OW]),
      .in_left_i  (lane[r][col_lsb(0, OW) +: OW]),
      .row_o      (row_q[r])
    );
  end

  assign bus.ifm_output0 = row_q[0][col_lsb(0, OW) +: OW];
  assign bus.ifm_output1 = row_q[0][col_lsb(1, OW) +: OW];
  assign bus.ifm_output2 = row_q[0][col_lsb(2, OW) +: OW];
  assign bus.ifm_output3 = row_q[1][col_lsb(0, OW) +: OW];
  assign bus.ifm_output4 = row_q[1][col_lsb(1, OW) +: OW];
  assign bus.ifm_output5 = row_q[1][col_lsb(2, OW) +: OW];
  assign bus.ifm_output6 = row_q[2][col_lsb(0, OW) +: OW];
  assign bus.ifm_output7 = row_q[2][col_lsb(1, OW) +: OW];
  assign bus.ifm_output8 = row_q[2][col_lsb(2, OW) +: OW];

endmodule

// File: tb/tb_ifm_buf.sv
// Randomized and directed bench for ifm_buf against a 3x3 array model of the window.
module tb_ifm_buf;

  logic clk;
  logic rst_n;

  ifm_buf_if #(.input_width(32), .output_width(8)) bus ();

  ifm_buf #(.input_width(32), .output_width(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] m [3][3];
  logic [7:0] lit_exp [9];
  bit         lit_vld;
  int         checks;
  int         failures;

  function automatic logic [7:0] bsel(input logic [31:0] w, input int c);
    return w[(2 - c) * 8 +: 8];
  endfunction

  // Single compare process: every negedge, DUT vs model (or zero under reset), plus literal pins.
  always @(negedge clk) begin
    logic [7:0] d [9];
    logic [7:0] e;
    d[0] = bus.ifm_output0; d[1] = bus.ifm_output1; d[2] = bus.ifm_output2;
    d[3] = bus.ifm_output3; d[4] = bus.ifm_output4; d[5] = bus.ifm_output5;
    d[6] = bus.ifm_output6; d[7] = bus.ifm_output7; d[8] = bus.ifm_output8;
    for (int i = 0; i < 9; i++) begin
      e = rst_n ? m[i / 3][i % 3] : 8'h00;
      checks++;
      if (d[i] !== e) begin
        failures++;
        $display("FAIL pix%0d t=%0t rst_n=%0b got=%02h exp=%02h", i, $time, rst_n, d[i], e);
      end
    end
    if (lit_vld) begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (m[i / 3][i % 3] !== lit_exp[i]) begin
          failures++;
          $display("FAIL model_pin%0d t=%0t model=%02h exp=%02h", i, $time, m[i / 3][i % 3], lit_exp[i]);
        end
        checks++;
        if (d[i] !== lit_exp[i]) begin
          failures++;
          $display("FAIL lit_pix%0d t=%0t got=%02h exp=%02h", i, $time, d[i], lit_exp[i]);
        end
      end
    end
  end

  task automatic clear_model();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[r][c] = 8'h00;
  endtask

  task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c2, input bit has_lit, input logic [71:0] lit);
    logic [7:0]  old [3][3];
    logic [31:0] in_w [3];
    @(negedge clk);
    #1;
    lit_vld = 1'b0;
    bus.ifm_read   = op;
    bus.ifm_input0 = a;
    bus.ifm_input1 = b;
    bus.ifm_input2 = c2;
    in_w[0] = a; in_w[1] = b; in_w[2] = c2;
    @(posedge clk);
    old = m;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        case (op)
          3'b000: m[r][c] = bsel(in_w[r], c);
          3'b001: m[r][c] = (c < 2) ? old[r][c + 1] : bsel(in_w[r], 2);
          3'b010: m[r][c] = (r < 2) ? old[r + 1][c] : bsel(in_w[2], c);
          3'b100: m[r][c] = (c > 0) ? old[r][c - 1] : bsel(in_w[r], 0);
          default: m[r][c] = old[r][c];
        endcase
      end
    end
    if (has_lit) begin
      for (int i = 0; i < 9; i++) lit_exp[i] = lit[(8 - i) * 8 +: 8];
      lit_vld = 1'b1;
    end
  endtask

  localparam logic [71:0] L_ALL   = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] L_RIGHT = 72'h02_03_0A_05_06_0B_08_09_0C;
  localparam logic [71:0] L_DOWN  = 72'h05_06_0B_08_09_0C_0D_0E_0F;
  localparam logic [71:0] L_LEFT  = 72'h0A_05_06_0A_08_09_0A_0D_0E;
  localparam logic [71:0] L_NONE  = 72'h0;

  initial begin
    logic [2:0] undef_ops [4];
    checks   = 0;
    failures = 0;
    lit_vld  = 1'b0;
    clear_model();
    // Hold reset with a live ALL request; the window must stay clear.
    rst_n = 1'b0;
    bus.ifm_read   = 3'b000;
    bus.ifm_input0 = 32'h11223344;
    bus.ifm_input1 = 32'h55667788;
    bus.ifm_input2 = 32'h99AABBCC;
    #15;
    bus.ifm_read = 3'b111;
    #2;
    rst_n = 1'b1;

    step(3'b000, 32'h00010203, 32'h00040506, 32'h00070809, 1'b1, L_ALL);
    step(3'b001, 32'h0000000A, 32'h0000000B, 32'h0000000C, 1'b1, L_RIGHT);
    step(3'b010, 32'h00000000, 32'h00000000, 32'h000D0E0F, 1'b1, L_DOWN);
    step(3'b100, 32'h000A0000, 32'h000A0000, 32'h000A0000, 1'b1, L_LEFT);
    undef_ops[0] = 3'b111; undef_ops[1] = 3'b011;
    undef_ops[2] = 3'b101; undef_ops[3] = 3'b110;
    for (int i = 0; i < 4; i++)
      step(undef_ops[i], $urandom, $urandom, $urandom, 1'b1, L_LEFT);
    // Upper byte is outside the pixel lanes.
    step(3'b000, 32'hFF010203, 32'hFF040506, 32'hFF070809, 1'b1, L_ALL);

    for (int n = 0; n < 300; n++)
      step(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'b0, L_NONE);

    // Asynchronous reset between edges with an ALL pending.
    step(3'b000, 32'h00AABBCC, 32'h00DDEEFF, 32'h00123456, 1'b0, L_NONE);
    #2;
    lit_vld = 1'b0;
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    #1;
    bus.ifm_read = 3'b111;
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 200; n++)
      step(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'b0, L_NONE);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifm_buf.md
Name: ifm_buf

Overview:
- 3x3 input-feature-map window register for the convolution datapath.
- Holds nine signed 8-bit pixels and loads the full window from three packed row words.
- Can also slide the window one pixel right, down or left, taking in only the new column or row.
- Sits between the IFM memory read path and the 3x3 MAC/PE array, which consumes the nine outputs in parallel.

Parameters:
- input_width, 32, width of each packed row input word; bits [23:0] carry 3 pixels, bits [input_width-1:24] are ignored.
- output_width, 8, width of one pixel and of each output port; the packing assumes 3*output_width <= input_width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ifm_read  input  3  window operation code, sampled at the rising edge of clk.
- ifm_input0  input  input_width  packed row/column source for window row 0.
- ifm_input1  input  input_width  packed row/column source for window row 1.
- ifm_input2  input  input_width  packed row/column source for window row 2.
- ifm_output0..ifm_output8  output  output_width each (signed)  window pixel w[r][c], where output index = 3*r + c; r is the row (0 = top), c is the column (0 = left).

Behaviour:
- Pixel packing in every input word: byte [23:16] is column 0, byte [15:8] is column 1, byte [7:0] is column 2.
- State is nine output_width registers w[0..2][0..2], and the outputs drive them directly. No combinational path runs from inputs to outputs, so latency is 1 clock.
- Reset (rst_n = 0, asynchronous): all nine registers clear to 0 immediately. They stay 0 while rst_n is low. Reset mid-operation discards the window.
- ifm_read codes, applied at each posedge:
  - ALL = 3'b000: for each r, w[r][0] <= input_r[23:16], w[r][1] <= input_r[15:8], w[r][2] <= input_r[7:0].
  - RIGHT = 3'b001: per row, w[r][0] <= w[r][1], w[r][1] <= w[r][2], w[r][2] <= input_r[7:0].
  - DOWN = 3'b010: w[0][*] <= w[1][*], w[1][*] <= w[2][*]; w[2][0..2] <= ifm_input2 bytes [23:16], [15:8], [7:0]. ifm_input0 and ifm_input1 are ignored.
  - LEFT = 3'b100: per row, w[r][2] <= w[r][1], w[r][1] <= w[r][0], w[r][0] <= input_r[23:16].
  - KEEP = 3'b111: all registers hold.
  - Undefined codes (011, 101, 110, or X): treated as KEEP.
- Input bytes that the current code does not select are don't-care.
- Pixels are copied bit-exact; there is no arithmetic, sign extension or saturation.
- Shifts use the pre-edge register values; all nine registers update simultaneously.

Decomposition:
- Shared package ifm_pkg holds:
  - the opcode localparams IFM_ALL, IFM_RIGHT, IFM_DOWN, IFM_LEFT, IFM_KEEP;
  - the byte-lane offsets for columns 0..2.
- One sub-module is natural: ifm_buf_row. It is one 3-pixel row register with load-all, shift-left-in-right, shift-right-in-left and hold operations.
  - The top instantiates it three times and muxes each row's parallel-load source, selecting its own input for ALL and the row below (or ifm_input2) for DOWN.

Test Plan:
- Reset: hold rst_n = 0 for 15 ns -> all outputs 0; assert rst_n low asynchronously mid-run -> outputs 0 before the next edge.
- ALL with inputs 0x00010203 / 0x00040506 / 0x00070809 -> outputs0..8 = 1,2,3,4,5,6,7,8,9 one cycle later.
- Then RIGHT with inputs 0x0A / 0x0B / 0x0C -> outputs = 2,3,0A,5,6,0B,8,9,0C.
- Then DOWN with ifm_input2 = 0x000D0E0F and inputs 0/1 = 0 -> outputs = 5,6,0B,8,9,0C,0D,0E,0F.
- Then LEFT with all inputs = 0x000A0000 -> outputs = 0A,5,6,0A,8,9,0A,0D,0E.
- KEEP (111) and undefined codes 011/101/110 with random inputs -> outputs unchanged. Upper byte [31:24] set to 0xFF on ALL -> ignored.
